int_ram_banked: RTL

INT_RAM_BANKED -- requirements
Module: int_ram_banked

---
 rtl/int_ram_banked.sv | 94 +++++++++
 1 files changed

// File: rtl/int_ram_banked.sv
// Banked word RAM with a registered read port and a self-clearing sweep.
// A sweep zeroes one address of every bank per cycle; it runs after reset and on clr.
module int_ram_banked #(
    parameter int DATA_WIDTH = 5,
    parameter int A_WIDTH    = 8,
    parameter int BS_WIDTH   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  we,
    input  logic [BS_WIDTH-1:0]   rs,
    input  logic [A_WIDTH-1:0]    address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  access_err
);

    localparam int RAM_DEPTH = 1 << A_WIDTH;
    localparam int NUM_BANKS = 1 << BS_WIDTH;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t               state, state_nxt;
    logic [A_WIDTH-1:0]   cnt, cnt_nxt;
    logic                 access;
    logic                 sweep_last;

    // Flat storage indexed by {bank, address}.
    logic [DATA_WIDTH-1:0] mem [NUM_BANKS*RAM_DEPTH];

    assign busy       = (state == CLEAR);
    assign access     = cs && !busy;
    assign sweep_last = (cnt == A_WIDTH'(RAM_DEPTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr) state_nxt = CLEAR;
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (sweep_last) state_nxt = IDLE;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // NOTE: the array has no reset; zeroing is done by the sweep so it can map to RAM.
    always_ff @(posedge clk) begin
        if (busy) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem[{BS_WIDTH'(b), cnt}] <= '0;
            end
        end else if (access && we) begin
            mem[{rs, address}] <= data_in;
        end
    end

    // data_out only loads on a read, so it holds across writes, idle and sweeps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            access_err <= 1'b0;
        end else begin
            valid_out  <= access && !we;
            access_err <= cs && busy;
            if (access && !we) data_out <= mem[{rs, address}];
        end
    end

endmodule
